// File: rtl/submit_table_cfg_arbiter_pkg.sv
// Shared definitions for the submit slot table configuration arbiter:
// FSM state encodings, requester ids and default geometry.
package submit_table_cfg_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_REJ   = 3'd2,
    ST_RD    = 3'd3,
    ST_RWAIT = 3'd4,
    ST_RACK  = 3'd5
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_RD_LAT = 2;

endpackage

// File: rtl/cfg_rr_arbiter2.sv
// Two-way round-robin pick with a last_grant register; the pick is purely
// combinational and last_grant only moves when the owner FSM allows it.
module cfg_rr_arbiter2
  import submit_table_cfg_arbiter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic any_req,
  output logic pick
);

  logic last_grant;

  assign any_req = req_a | req_b;

  // With both requesting, the side that did not win last time goes next.
  always_comb begin
    pick = ~last_grant;
    if (req_a && !req_b) begin
      pick = REQ_A;
    end else if (!req_a && req_b) begin
      pick = REQ_B;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= REQ_B;
    end else if (update && any_req) begin
      last_grant <= pick;
    end
  end

endmodule

// File: rtl/submit_table_cfg_arbiter.sv
// Shares the submit slot table config port between the management interface (A)
// and the config-frame parser (B): one single-word read or write in flight at a time.
module submit_table_cfg_arbiter
  import submit_table_cfg_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int RD_LAT = DEF_RD_LAT
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_table_lock,
  input  logic              i_a_req,
  input  logic              i_a_wr,
  input  logic [ADDR_W-1:0] iv_a_addr,
  input  logic [DATA_W-1:0] iv_a_wdata,
  input  logic              i_b_req,
  input  logic              i_b_wr,
  input  logic [ADDR_W-1:0] iv_b_addr,
  input  logic [DATA_W-1:0] iv_b_wdata,
  output logic              o_a_ack,
  output logic              o_a_err,
  output logic [DATA_W-1:0] ov_a_rdata,
  output logic              o_b_ack,
  output logic              o_b_err,
  output logic [DATA_W-1:0] ov_b_rdata,
  output logic [ADDR_W-1:0] ov_table_addr,
  output logic [DATA_W-1:0] ov_table_wdata,
  output logic              o_table_wr,
  output logic              o_table_rd,
  input  logic [DATA_W-1:0] iv_table_rdata,
  output logic [7:0]        ov_reject_cnt
);

  localparam logic [2:0] LAST_WAIT = 3'(RD_LAT - 1);

  state_t            state, state_next;
  logic              pick, any_req, owner;
  logic [2:0]        wait_cnt;
  logic              grant_en, win_wr, wait_done, rejecting;
  logic              a_ack_next, b_ack_next, a_err_next, b_err_next;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  cfg_rr_arbiter2 u_rr (
    .clk     (i_clk),
    .rst_n   (i_rst_n),
    .req_a   (i_a_req),
    .req_b   (i_b_req),
    .update  (state == ST_IDLE),
    .any_req (any_req),
    .pick    (pick)
  );

  assign win_wr    = (pick == REQ_B) ? i_b_wr     : i_a_wr;
  assign win_addr  = (pick == REQ_B) ? iv_b_addr  : iv_a_addr;
  assign win_wdata = (pick == REQ_B) ? iv_b_wdata : iv_a_wdata;

  always_comb begin
    state_next = state;
    grant_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          grant_en = 1'b1;
          if (win_wr) begin
            state_next = i_table_lock ? ST_REJ : ST_WR;
          end else begin
            state_next = ST_RD;
          end
        end
      end
      ST_WR:    state_next = ST_IDLE;
      ST_REJ:   state_next = ST_IDLE;
      ST_RD:    state_next = ST_RWAIT;
      ST_RWAIT: if (wait_cnt == LAST_WAIT) state_next = ST_RACK;
      ST_RACK:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Write acks are issued at grant so they line up with the strobe; read acks
  // are issued as the data is captured so rdata is valid from the ack cycle.
  assign wait_done  = (state == ST_RWAIT) && (wait_cnt == LAST_WAIT);
  assign rejecting  = grant_en && win_wr && i_table_lock;
  assign a_ack_next = (grant_en && win_wr && pick == REQ_A) || (wait_done && owner == REQ_A);
  assign b_ack_next = (grant_en && win_wr && pick == REQ_B) || (wait_done && owner == REQ_B);
  assign a_err_next = rejecting && pick == REQ_A;
  assign b_err_next = rejecting && pick == REQ_B;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state          <= ST_IDLE;
      owner          <= REQ_A;
      wait_cnt       <= 3'd0;
      o_a_ack        <= 1'b0;
      o_a_err        <= 1'b0;
      ov_a_rdata     <= '0;
      o_b_ack        <= 1'b0;
      o_b_err        <= 1'b0;
      ov_b_rdata     <= '0;
      ov_table_addr  <= '0;
      ov_table_wdata <= '0;
      o_table_wr     <= 1'b0;
      o_table_rd     <= 1'b0;
      ov_reject_cnt  <= 8'd0;
    end else begin
      state      <= state_next;
      o_table_wr <= grant_en && win_wr && !i_table_lock;
      o_table_rd <= grant_en && !win_wr;
      o_a_ack    <= a_ack_next;
      o_b_ack    <= b_ack_next;
      o_a_err    <= a_err_next;
      o_b_err    <= b_err_next;
      wait_cnt   <= (state == ST_RWAIT) ? wait_cnt + 3'd1 : 3'd0;
      if (grant_en) begin
        owner          <= pick;
        ov_table_addr  <= win_addr;
        ov_table_wdata <= win_wdata;
      end
      if (wait_done) begin
        if (owner == REQ_B) begin
          ov_b_rdata <= iv_table_rdata;
        end else begin
          ov_a_rdata <= iv_table_rdata;
        end
      end
      if (rejecting && ov_reject_cnt != 8'hFF) begin
        ov_reject_cnt <= ov_reject_cnt + 8'd1;
      end
    end
  end

endmodule
